// File: rtl/tile_reg_bridge.sv
// OCL-to-tile register bridge. It forwards one OCL access at a time to the components of tile
// TILE_ID as single-cycle strobes, and bounds the time it waits for read data from a component.
module tile_reg_bridge #(
  parameter logic [7:0]  TILE_ID = 8'd0,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ocl_awvalid,
  output logic        ocl_awready,
  input  logic [31:0] ocl_awaddr,
  input  logic        ocl_wvalid,
  output logic        ocl_wready,
  input  logic [31:0] ocl_wdata,
  output logic        ocl_bvalid,
  input  logic        ocl_bready,
  input  logic        ocl_arvalid,
  output logic        ocl_arready,
  input  logic [31:0] ocl_araddr,
  output logic        ocl_rvalid,
  input  logic        ocl_rready,
  output logic [31:0] ocl_rdata,
  output logic        reg_wvalid,
  output logic [15:0] reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        reg_arvalid,
  output logic [15:0] reg_araddr,
  input  logic        reg_rvalid,
  input  logic [31:0] reg_rdata,
  output logic [7:0]  timeout_count,
  output logic [2:0]  fsm_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] W_DATA  = 3'd1;
  localparam logic [2:0] W_ISSUE = 3'd2;
  localparam logic [2:0] W_RESP  = 3'd3;
  localparam logic [2:0] R_ISSUE = 3'd4;
  localparam logic [2:0] R_WAIT  = 3'd5;
  localparam logic [2:0] R_RESP  = 3'd6;

  localparam logic [15:0] TIMEOUT_CYCLES = 16'(TIMEOUT);
  localparam logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF;

  logic [2:0]  state;
  logic [7:0]  tile_q;
  logic [15:0] addr_lo_q;
  logic [15:0] wait_cnt;
  logic [15:0] wait_next;
  logic        tile_hit;
  logic        unused_addr_bits;

  assign tile_hit         = (tile_q == TILE_ID);
  assign wait_next        = wait_cnt + 16'd1;
  assign unused_addr_bits = ^{ocl_awaddr[31:24], ocl_araddr[31:24]};
  assign fsm_state        = state;

  // OCL channels: a transfer happens on a rising edge where valid and ready are both 1;
  // valid is held until that edge. Ready depends only on state (arready also yields to awvalid).
  assign ocl_awready = (state == IDLE);
  assign ocl_arready = (state == IDLE) && !ocl_awvalid;
  assign ocl_wready  = (state == W_DATA);
  assign ocl_bvalid  = (state == W_RESP);
  assign ocl_rvalid  = (state == R_RESP);
  assign reg_wvalid  = (state == W_ISSUE) && tile_hit;
  assign reg_arvalid = (state == R_ISSUE) && tile_hit;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      tile_q        <= '0;
      addr_lo_q     <= '0;
      wait_cnt      <= '0;
      ocl_rdata     <= '0;
      timeout_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ocl_awvalid) begin
            tile_q    <= ocl_awaddr[23:16];
            addr_lo_q <= ocl_awaddr[15:0];
            state     <= W_DATA;
          end else if (ocl_arvalid) begin
            tile_q    <= ocl_araddr[23:16];
            addr_lo_q <= ocl_araddr[15:0];
            state     <= R_ISSUE;
          end
        end
        W_DATA: begin
          if (ocl_wvalid) state <= W_ISSUE;
        end
        W_ISSUE: state <= W_RESP;
        W_RESP: begin
          if (ocl_bready) state <= IDLE;
        end
        R_ISSUE: begin
          wait_cnt <= '0;
          if (tile_hit) begin
            state <= R_WAIT;
          end else begin
            ocl_rdata <= '0;
            state     <= R_RESP;
          end
        end
        R_WAIT: begin
          wait_cnt <= wait_next;
          // Data arriving on the last allowed cycle still wins over the timeout.
          if (reg_rvalid) begin
            ocl_rdata <= reg_rdata;
            state     <= R_RESP;
          end else if (wait_next == TIMEOUT_CYCLES) begin
            ocl_rdata <= TIMEOUT_DATA;
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
            state <= R_RESP;
          end
        end
        R_RESP: begin
          if (ocl_rready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Component-side address/data only change when a strobe is about to be issued.
  always_ff @(posedge clk) begin
    if (rstn && state == W_DATA && ocl_wvalid && tile_hit) begin
      reg_waddr <= addr_lo_q;
      reg_wdata <= ocl_wdata;
    end
    if (rstn && state == IDLE && !ocl_awvalid && ocl_arvalid && ocl_araddr[23:16] == TILE_ID) begin
      reg_araddr <= ocl_araddr[15:0];
    end
  end

endmodule

// File: tb/tb_tile_reg_bridge.sv
// Bench for tile_reg_bridge (TILE_ID=3, TIMEOUT=8): directed and random OCL traffic against a
// transaction-level model, with a monitor that pops expected strobes and responses.
module tb_tile_reg_bridge;

  localparam logic [7:0] TILE = 8'd3;
  localparam int         TMO  = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ocl_awvalid, ocl_awready;
  logic [31:0] ocl_awaddr;
  logic        ocl_wvalid, ocl_wready;
  logic [31:0] ocl_wdata;
  logic        ocl_bvalid, ocl_bready;
  logic        ocl_arvalid, ocl_arready;
  logic [31:0] ocl_araddr;
  logic        ocl_rvalid, ocl_rready;
  logic [31:0] ocl_rdata;
  logic        reg_wvalid;
  logic [15:0] reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_arvalid;
  logic [15:0] reg_araddr;
  logic        reg_rvalid;
  logic [31:0] reg_rdata;
  logic [7:0]  timeout_count;
  logic [2:0]  fsm_state;

  tile_reg_bridge #(.TILE_ID(TILE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .ocl_awvalid(ocl_awvalid), .ocl_awready(ocl_awready), .ocl_awaddr(ocl_awaddr),
    .ocl_wvalid(ocl_wvalid), .ocl_wready(ocl_wready), .ocl_wdata(ocl_wdata),
    .ocl_bvalid(ocl_bvalid), .ocl_bready(ocl_bready),
    .ocl_arvalid(ocl_arvalid), .ocl_arready(ocl_arready), .ocl_araddr(ocl_araddr),
    .ocl_rvalid(ocl_rvalid), .ocl_rready(ocl_rready), .ocl_rdata(ocl_rdata),
    .reg_wvalid(reg_wvalid), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .reg_arvalid(reg_arvalid), .reg_araddr(reg_araddr),
    .reg_rvalid(reg_rvalid), .reg_rdata(reg_rdata),
    .timeout_count(timeout_count), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [47:0] exp_wr_q[$];
  logic [15:0] exp_ar_q[$];
  logic [31:0] exp_b_q[$];
  logic [31:0] exp_rd_q[$];
  int          test_cnt = 0;
  int          fail_cnt = 0;
  int          model_to = 0;
  logic [47:0] last_w;
  bit          last_w_known = 1'b0;
  logic [15:0] last_ar;
  bit          last_ar_known = 1'b0;
  bit          hold_ready = 1'b0;
  bit          r_pending = 1'b0;
  bit          b_pending = 1'b0;
  logic [31:0] r_prev;
  logic [47:0] mon_e48;
  logic [15:0] mon_e16;
  logic [31:0] mon_e32;
  logic [31:0] ta, td, ra, rd;
  int          tk, wn;

  task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check_word(name, {63'd0, act}, {63'd0, exp});
  endtask

  task automatic report_timeout(input string name);
    test_cnt++;
    fail_cnt++;
    $display("FAIL %s: DUT did not respond within the cycle bound (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  task automatic write_expect(input logic [31:0] a, input logic [31:0] d);
    if (a[23:16] == TILE) begin
      exp_wr_q.push_back({a[15:0], d});
      last_w       = {a[15:0], d};
      last_w_known = 1'b1;
    end
    exp_b_q.push_back(a);
  endtask

  // k: wait cycle (1-based) on which the component answers; 0 = never answers.
  task automatic read_expect(input logic [31:0] a, input int k, input logic [31:0] d);
    if (a[23:16] != TILE) begin
      exp_rd_q.push_back(32'h0);
    end else begin
      exp_ar_q.push_back(a[15:0]);
      last_ar       = a[15:0];
      last_ar_known = 1'b1;
      if (k >= 1 && k <= TMO) begin
        exp_rd_q.push_back(d);
      end else begin
        exp_rd_q.push_back(32'hDEAD_BEEF);
        if (model_to < 255) model_to++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic aw_handshake();
    int n = 0;
    #1;
    while (!ocl_awready && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) report_timeout("aw_accept");
    @(negedge clk);
    ocl_awvalid = 1'b0;
  endtask

  task automatic ar_handshake();
    int n = 0;
    #1;
    while (!ocl_arready && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) report_timeout("ar_accept");
    @(negedge clk);
    ocl_arvalid = 1'b0;
  endtask

  task automatic aw_phase(input logic [31:0] a);
    @(negedge clk);
    ocl_awvalid = 1'b1;
    ocl_awaddr  = a;
    aw_handshake();
  endtask

  task automatic ar_phase(input logic [31:0] a);
    @(negedge clk);
    ocl_arvalid = 1'b1;
    ocl_araddr  = a;
    ar_handshake();
  endtask

  task automatic w_phase(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    ocl_wvalid = 1'b1;
    ocl_wdata  = d;
    #1;
    while (!ocl_wready && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) report_timeout("w_accept");
    @(negedge clk);
    ocl_wvalid = 1'b0;
    ocl_wdata  = $urandom;
    #1;
    check_bit("w_issue_strobe", reg_wvalid, a[23:16] == TILE);
    @(negedge clk);
    #1;
    check_bit("b_latency", ocl_bvalid, 1'b1);
  endtask

  // Entered at the falling edge just after the read address was accepted.
  task automatic read_data_phase(input logic [31:0] a, input int k, input logic [31:0] d);
    if (a[23:16] != TILE) begin
      @(negedge clk); #1;
      check_bit("rd_miss_latency", ocl_rvalid, 1'b1);
    end else if (k >= 1 && k <= TMO) begin
      repeat (k) @(negedge clk);
      reg_rvalid = 1'b1;
      reg_rdata  = d;
      @(negedge clk);
      reg_rvalid = 1'b0;
      reg_rdata  = $urandom;
      #1;
      check_bit("rd_hit_latency", ocl_rvalid, 1'b1);
    end else begin
      repeat (TMO) @(negedge clk);
      #1;
      check_bit("rd_wait_no_rvalid", ocl_rvalid, 1'b0);
      @(negedge clk); #1;
      check_bit("rd_timeout_latency", ocl_rvalid, 1'b1);
      if (k > TMO) begin
        // late component data must be ignored
        repeat (k - TMO - 1) @(negedge clk);
        reg_rvalid = 1'b1;
        reg_rdata  = $urandom;
        @(negedge clk);
        reg_rvalid = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_wr_q.size() + exp_ar_q.size() + exp_b_q.size() + exp_rd_q.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      report_timeout("drain");
      exp_wr_q.delete(); exp_ar_q.delete(); exp_b_q.delete(); exp_rd_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic post_checks();
    check_word("timeout_count", 64'(timeout_count), 64'(model_to));
    if (last_w_known) check_word("reg_write_hold", 64'({reg_waddr, reg_wdata}), 64'(last_w));
    if (last_ar_known) check_word("reg_araddr_hold", 64'(reg_araddr), 64'(last_ar));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    write_expect(a, d);
    aw_phase(a);
    w_phase(a, d);
    drain();
    post_checks();
  endtask

  task automatic do_read(input logic [31:0] a, input int k, input logic [31:0] d);
    read_expect(a, k, d);
    ar_phase(a);
    read_data_phase(a, k, d);
    drain();
    post_checks();
  endtask

  // ---------------- response back-pressure ----------------
  initial begin
    ocl_bready = 1'b0;
    ocl_rready = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_ready) begin
        ocl_bready = 1'b0;
        ocl_rready = 1'b0;
      end else begin
        ocl_bready = 1'($urandom_range(0, 1));
        ocl_rready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) begin
        r_pending = 1'b0;
        b_pending = 1'b0;
      end else begin
        if (reg_wvalid) begin
          if (exp_wr_q.size() == 0) begin
            test_cnt++; fail_cnt++;
            $display("FAIL reg_wvalid_unexpected: got strobe to 0x%0h, expected none", reg_waddr);
          end else begin
            mon_e48 = exp_wr_q.pop_front();
            check_word("reg_write", 64'({reg_waddr, reg_wdata}), 64'(mon_e48));
          end
        end
        if (reg_arvalid) begin
          if (exp_ar_q.size() == 0) begin
            test_cnt++; fail_cnt++;
            $display("FAIL reg_arvalid_unexpected: got strobe to 0x%0h, expected none", reg_araddr);
          end else begin
            mon_e16 = exp_ar_q.pop_front();
            check_word("reg_read_addr", 64'(reg_araddr), 64'(mon_e16));
          end
        end
        if (b_pending) check_bit("bvalid_held", ocl_bvalid, 1'b1);
        b_pending = ocl_bvalid && !ocl_bready;
        if (ocl_bvalid && ocl_bready) begin
          if (exp_b_q.size() == 0) begin
            test_cnt++; fail_cnt++;
            $display("FAIL bvalid_unexpected: got bvalid=1, expected 0");
          end else begin
            mon_e32 = exp_b_q.pop_front();
          end
        end
        if (r_pending) check_bit("rvalid_held", ocl_rvalid, 1'b1);
        if (ocl_rvalid) begin
          if (r_pending) check_word("rdata_stable", 64'(ocl_rdata), 64'(r_prev));
          if (ocl_rready) begin
            r_pending = 1'b0;
            if (exp_rd_q.size() == 0) begin
              test_cnt++; fail_cnt++;
              $display("FAIL rvalid_unexpected: got rdata 0x%0h, expected no response", ocl_rdata);
            end else begin
              mon_e32 = exp_rd_q.pop_front();
              check_word("rdata", 64'(ocl_rdata), 64'(mon_e32));
            end
          end else begin
            r_pending = 1'b1;
            r_prev    = ocl_rdata;
          end
        end else begin
          r_pending = 1'b0;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    fail_cnt++;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rstn        = 1'b0;
    ocl_awvalid = 1'b0; ocl_awaddr = '0;
    ocl_wvalid  = 1'b0; ocl_wdata  = '0;
    ocl_arvalid = 1'b0; ocl_araddr = '0;
    reg_rvalid  = 1'b0; reg_rdata  = '0;
    repeat (3) @(negedge clk);
    #1;
    check_bit("rst_awready", ocl_awready, 1'b1);
    check_bit("rst_wready", ocl_wready, 1'b0);
    check_bit("rst_bvalid", ocl_bvalid, 1'b0);
    check_bit("rst_rvalid", ocl_rvalid, 1'b0);
    check_bit("rst_reg_wvalid", reg_wvalid, 1'b0);
    check_bit("rst_reg_arvalid", reg_arvalid, 1'b0);
    check_word("rst_rdata", 64'(ocl_rdata), 64'd0);
    check_word("rst_timeout_count", 64'(timeout_count), 64'd0);
    rstn = 1'b1;

    // directed: matching write, foreign write, read with delayed data, single timeout
    do_write(32'h0003_0204, 32'h1234_5678);
    do_write(32'h0005_0204, 32'hAAAA_5555);
    do_read(32'h0003_0110, 4, 32'hCAFE_0001);
    do_read(32'h0003_0114, 1, 32'h0BAD_F00D);
    do_read(32'h0007_0110, 3, 32'h1111_2222);
    do_read(32'h0003_0118, 0, 32'h0);
    do_read(32'h0003_011C, TMO, 32'h5A5A_A5A5);

    // bready held low for 10 cycles
    #3 hold_ready = 1'b1;
    fork
      do_write(32'h0003_0A08, 32'h7777_0001);
      begin
        wn = 0;
        @(negedge clk); #3;
        while (!ocl_bvalid && wn < 100) begin @(negedge clk); #3; wn++; end
        if (wn >= 100) report_timeout("bvalid_hold_wait");
        repeat (10) begin @(negedge clk); #3; check_bit("bvalid_under_hold", ocl_bvalid, 1'b1); end
        hold_ready = 1'b0;
      end
    join

    // rready held low for 10 cycles
    #3 hold_ready = 1'b1;
    fork
      do_read(32'h0003_0A0C, 3, 32'hBEEF_0042);
      begin
        wn = 0;
        @(negedge clk); #3;
        while (!ocl_rvalid && wn < 100) begin @(negedge clk); #3; wn++; end
        if (wn >= 100) report_timeout("rvalid_hold_wait");
        repeat (10) begin
          @(negedge clk); #3;
          check_bit("rvalid_under_hold", ocl_rvalid, 1'b1);
          check_word("rdata_under_hold", 64'(ocl_rdata), 64'h0000_0000_BEEF_0042);
        end
        hold_ready = 1'b0;
      end
    join

    // simultaneous write and read requests
    ta = 32'h0003_0300; td = 32'h0102_0304;
    ra = 32'h0003_0304; rd = 32'h0A0B_0C0D;
    write_expect(ta, td);
    read_expect(ra, 2, rd);
    @(negedge clk);
    ocl_awvalid = 1'b1; ocl_awaddr = ta;
    ocl_arvalid = 1'b1; ocl_araddr = ra;
    #1;
    check_bit("ar_blocked_by_aw", ocl_arready, 1'b0);
    aw_handshake();
    w_phase(ta, td);
    ar_handshake();
    check_word("write_done_before_read", 64'(exp_b_q.size()), 64'd0);
    read_data_phase(ra, 2, rd);
    drain();
    post_checks();

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      ta = $urandom;
      if ($urandom_range(0, 2) != 0) ta[23:16] = TILE;
      td = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        do_write(ta, td);
      end else begin
        tk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(1, TMO));
        do_read(ta, tk, td);
      end
    end

    // timeout counter saturation
    for (int i = 0; i < 300; i++) begin
      ta = {16'h0003, 16'($urandom_range(0, 65535))};
      do_read(ta, 0, 32'h0);
    end

    // reset while waiting for read data
    ra = 32'h0003_0440;
    exp_ar_q.push_back(16'h0440);
    last_ar = 16'h0440;
    last_ar_known = 1'b1;
    ar_phase(ra);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_to = 0;
    #1;
    check_word("rst_mid_read_rdata", 64'(ocl_rdata), 64'd0);
    check_word("rst_mid_read_timeout_count", 64'(timeout_count), 64'd0);
    check_bit("rst_mid_read_awready", ocl_awready, 1'b1);
    repeat (6) begin @(negedge clk); #1; check_bit("no_rvalid_after_reset", ocl_rvalid, 1'b0); end
    drain();
    post_checks();

    // reset while waiting for write data
    aw_phase(32'h0003_0550);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      check_bit("no_strobe_or_b_after_reset", reg_wvalid | ocl_bvalid, 1'b0);
    end
    drain();
    post_checks();

    // a little more traffic after the resets
    for (int i = 0; i < 20; i++) begin
      ta = $urandom;
      if ($urandom_range(0, 1) == 1) ta[23:16] = TILE;
      td = $urandom;
      if ($urandom_range(0, 1) == 1) do_write(ta, td);
      else do_read(ta, int'($urandom_range(0, 10)), td);
    end

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/tile_reg_bridge.md
TILE_REG_BRIDGE -- requirements
Module: tile_reg_bridge

Interface
REQ-001 Parameter TILE_ID, default 0: 8-bit tile index this bridge answers to; compared against addr[23:16].
REQ-002 Parameter TIMEOUT, default 255: max cycles waiting for component read data; range 1..65535.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 ocl_awvalid / ocl_awready  in / out  1 / 1  write-address handshake from the OCL arbiter.
REQ-006 ocl_awaddr  in  32  write address; [23:16] tile, [15:8] component id, [7:0] register offset.
REQ-007 ocl_wvalid / ocl_wready  in / out  1 / 1  write-data handshake.
REQ-008 ocl_wdata  in  32  write data.
REQ-009 ocl_bvalid / ocl_bready  out / in  1 / 1  write-response handshake.
REQ-010 ocl_arvalid / ocl_arready  in / out  1 / 1  read-address handshake.
REQ-011 ocl_araddr  in  32  read address, same field layout as ocl_awaddr.
REQ-012 ocl_rvalid / ocl_rready  out / in  1 / 1  read-data handshake.
REQ-013 ocl_rdata  out  32  read data (reg_data_t).
REQ-014 reg_wvalid  out  1  one-cycle write strobe to tile components.
REQ-015 reg_waddr / reg_wdata  out  16 / 32  latched addr[15:0] and data for the strobe.
REQ-016 reg_arvalid  out  1  one-cycle read strobe to tile components.
REQ-017 reg_araddr  out  16  latched addr[15:0] for the read.
REQ-018 reg_rvalid / reg_rdata  in / in  1 / 32  component read return; no back-pressure.
REQ-019 timeout_count  out  8  saturating count of read timeouts since reset.

Function
REQ-020 FSM states SHALL be IDLE, W_DATA, W_ISSUE, W_RESP, R_ISSUE, R_WAIT, R_RESP; one transaction in flight at a time.
REQ-021 ocl_awready SHALL be 1 only in IDLE; ocl_arready SHALL be 1 only in IDLE with ocl_awvalid=0 (write wins a simultaneous request).
REQ-022 IDLE & awvalid: latch awaddr, go W_DATA; IDLE & arvalid & !awvalid: latch araddr, go R_ISSUE.
REQ-023 ocl_wready SHALL be 1 only in W_DATA; on wvalid latch wdata, go W_ISSUE.
REQ-024 W_ISSUE (one cycle): reg_wvalid=1 iff latched addr[23:16]==TILE_ID; otherwise the write is silently dropped; go W_RESP.
REQ-025 W_RESP: ocl_bvalid=1, held until bready; return to IDLE on the bready cycle.
REQ-026 R_ISSUE (one cycle): reg_arvalid=1 iff addr[23:16]==TILE_ID, clear wait counter, go R_WAIT; on tile mismatch go directly to R_RESP with ocl_rdata=32'h0.
REQ-027 R_WAIT: counter increments each cycle; reg_rvalid latches reg_rdata into ocl_rdata, go R_RESP.
REQ-028 R_WAIT: counter reaching TIMEOUT with no reg_rvalid SHALL load ocl_rdata=32'hDEAD_BEEF, increment timeout_count (saturate at 255), go R_RESP; reg_rvalid on that same cycle takes priority (no timeout).
REQ-029 R_RESP: ocl_rvalid=1, ocl_rdata stable, held until rready; return to IDLE.
REQ-030 reg_rvalid outside R_WAIT SHALL be ignored.
REQ-031 Minimum latency: write aw-accept to bvalid 3 cycles after wvalid accept path (IDLE->W_DATA->W_ISSUE->W_RESP); read arready to rvalid = 3 cycles with reg_rvalid on first R_WAIT cycle.
REQ-032 reg_waddr/reg_wdata/reg_araddr SHALL hold their last values between strobes.

Reset
REQ-033 rstn=0 SHALL force state IDLE, all valid/strobe outputs 0, ocl_rdata=0, timeout_count=0, counter=0 on the next edge.
REQ-034 Reset mid-transaction SHALL abandon it with no response and no component strobe.

Verification
REQ-035 TILE_ID=3: aw 0x0003_0204, w 0x1234_5678 -> one reg_wvalid, reg_waddr=0x0204, reg_wdata=0x1234_5678, one bvalid.
REQ-036 aw 0x0005_0204 -> no reg_wvalid, bvalid still returned.
REQ-037 ar 0x0003_0110, reg_rvalid after 4 cycles with 0xCAFE_0001 -> rvalid, rdata=0xCAFE_0001.
REQ-038 TIMEOUT=8, ar with no reg_rvalid -> rdata=0xDEAD_BEEF after 8 wait cycles, timeout_count=1; 300 timeouts -> saturates 255.
REQ-039 awvalid and arvalid same cycle -> write completes first, read accepted afterwards.
REQ-040 bready/rready held low 10 cycles -> bvalid/rvalid and rdata stable; rstn pulse in R_WAIT -> IDLE, no rvalid.
